// File: rtl/grp_mux_pkg.sv
// Shared constants and helpers for the group selector / scanner.
package grp_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned MAX_GROUPS = 16;

    // Index port width: clog2(groups), never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned groups);
        int unsigned w;
        w = $clog2(groups);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [MAX_GROUPS-1:0] onehot_dec(input logic [3:0] idx);
        logic [MAX_GROUPS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/grp_mux_dwell_ctr.sv
// Dwell counter and group-index register: manual follow of sel, or automatic scan with wrap pulse.
module grp_mux_dwell_ctr
    import grp_mux_pkg::*;
#(
    parameter int unsigned GROUPS = 2,
    parameter int unsigned DWELL  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           mode,
    input  logic [sel_width(GROUPS)-1:0]   sel,
    output logic [sel_width(GROUPS)-1:0]   cur_idx,
    output logic [sel_width(GROUPS)-1:0]   idx_nxt_c,
    output logic                           wrap
);

    localparam int unsigned     SELW     = sel_width(GROUPS);
    localparam int unsigned     CW       = $clog2(DWELL + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] IDX_LAST = SELW'(GROUPS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wrap_nxt;
    logic          idx_valid;

    // Compare at 32 bits so a power-of-two GROUPS never aliases to zero.
    assign idx_valid = 32'(cur_idx) < GROUPS;

    always_comb begin
        cnt_nxt   = cnt;
        idx_nxt_c = cur_idx;
        wrap_nxt  = 1'b0;
        if (en) begin
            if (mode == MODE_MANUAL) begin
                cnt_nxt   = '0;
                idx_nxt_c = sel;
            end else if (!idx_valid) begin
                cnt_nxt   = '0;
                idx_nxt_c = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                if (cur_idx == IDX_LAST) begin
                    idx_nxt_c = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    idx_nxt_c = cur_idx + SELW'(1);
                end
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cur_idx <= '0;
            wrap    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            cur_idx <= idx_nxt_c;
            wrap    <= wrap_nxt;
        end
    end

endmodule

// File: rtl/group_mux_scan.sv
// Registered GROUPS-way selector of WIDTH-bit groups with manual select or automatic dwell scan.
module group_mux_scan
    import grp_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned GROUPS = 2,
    parameter int unsigned DWELL  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [GROUPS*WIDTH-1:0]      data_in,
    input  logic [sel_width(GROUPS)-1:0] sel,
    input  logic                         mode,
    input  logic                         en,
    output logic [WIDTH-1:0]             data_out,
    output logic [sel_width(GROUPS)-1:0] cur_idx,
    output logic [GROUPS-1:0]            grp_onehot,
    output logic                         wrap,
    output logic                         sel_err
);

    localparam int unsigned SELW = sel_width(GROUPS);

    logic [WIDTH-1:0]  grp [GROUPS];
    logic [SELW-1:0]   idx_nxt;
    logic              nxt_valid;
    logic [WIDTH-1:0]  data_nxt;
    logic [GROUPS-1:0] onehot_nxt;
    logic              err_nxt;

    for (genvar g = 0; g < GROUPS; g++) begin : g_split
        assign grp[g] = data_in[g*WIDTH +: WIDTH];
    end

    grp_mux_dwell_ctr #(
        .GROUPS (GROUPS),
        .DWELL  (DWELL)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .cur_idx   (cur_idx),
        .idx_nxt_c (idx_nxt),
        .wrap      (wrap)
    );

    // Payload follows the index being loaded so data_out always matches cur_idx.
    always_comb begin
        nxt_valid  = 32'(idx_nxt) < GROUPS;
        data_nxt   = '0;
        onehot_nxt = '0;
        err_nxt    = (mode == MODE_MANUAL) && !nxt_valid;
        if (nxt_valid) begin
            data_nxt   = grp[idx_nxt];
            onehot_nxt = GROUPS'(onehot_dec(4'(idx_nxt)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            grp_onehot <= GROUPS'(1);
            sel_err    <= 1'b0;
        end else if (en) begin
            data_out   <= data_nxt;
            grp_onehot <= onehot_nxt;
            sel_err    <= err_nxt;
        end
    end

endmodule
